sme_stim_driver: RTL and testbench

//  Transmit-side counterpart of the string-matching engine. Buffers one string
//  (<=STR_MAX chars) and one pattern (<=PAT_MAX chars) written by a host, replays

---
 rtl/sme_stim_if.sv | 37 +++
 rtl/sme_stim_driver.sv | 199 +++++++++++++++++++
 tb/tb_sme_stim_driver.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_stim_if.sv
// Host/engine bus of the string-matching stimulus driver.
// The driver takes the slave view; the sequencer/engine model takes the master view.
interface sme_stim_if;
    logic       host_wr_en;
    logic       host_sel;
    logic       host_clr;
    logic [7:0] host_data;
    logic       start;
    logic       send_str;
    logic       busy;
    logic       host_err;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;
    logic       res_valid;
    logic       res_match;
    logic [4:0] res_index;
    logic       res_timeout;
    logic [1:0] dbg_state;

    modport master (
        output host_wr_en, host_sel, host_clr, host_data, start, send_str,
        output valid, match, match_index,
        input  busy, host_err, chardata, isstring, ispattern,
        input  res_valid, res_match, res_index, res_timeout, dbg_state
    );

    modport slave (
        input  host_wr_en, host_sel, host_clr, host_data, start, send_str,
        input  valid, match, match_index,
        output busy, host_err, chardata, isstring, ispattern,
        output res_valid, res_match, res_index, res_timeout, dbg_state
    );
endinterface

// File: rtl/sme_stim_driver.sv
// Buffers one string and one pattern from the host, replays them to the matching
// engine, then returns the engine's result (or a timeout) to the host.
module sme_stim_driver #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 1023
) (
    input logic       clk,
    input logic       reset,
    sme_stim_if.slave bus
);
    localparam int SW  = $clog2(STR_MAX + 1);
    localparam int PW  = $clog2(PAT_MAX + 1);
    localparam int SAW = $clog2(STR_MAX);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND_STR = 2'd1,
        SEND_PAT = 2'd2,
        WAIT_RES = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SW-1:0] str_len_q;
    logic [PW-1:0] pat_len_q;
    logic          str_sent_q;
    logic [7:0]    str_mem [STR_MAX];
    logic [7:0]    pat_mem [PAT_MAX];

    logic          idle, str_full, pat_full, sel_full;
    logic          clr_acc, wr_acc, wr_rej;
    logic          start_rej, fin_valid, fin_timeout;
    logic [7:0]    chardata_d;

    logic          busy_q, host_err_q, isstring_q, ispattern_q;
    logic [7:0]    chardata_q;
    logic          res_valid_q, res_match_q, res_timeout_q;
    logic [4:0]    res_index_q;

    assign idle     = (state_q == IDLE);
    assign str_full = (str_len_q == SW'(STR_MAX));
    assign pat_full = (pat_len_q == PW'(PAT_MAX));
    assign sel_full = bus.host_sel ? pat_full : str_full;

    // Clear wins over a same-cycle write; anything else that cannot be stored is an error.
    assign clr_acc = idle && bus.host_clr;
    assign wr_acc  = idle && bus.host_wr_en && !bus.host_clr && !sel_full;
    assign wr_rej  = bus.host_wr_en && !clr_acc && !wr_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        start_rej   = 1'b0;
        fin_valid   = 1'b0;
        fin_timeout = 1'b0;
        chardata_d  = 8'h00;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if ((pat_len_q == '0) ||
                        (bus.send_str && (str_len_q == '0)) ||
                        (!bus.send_str && !str_sent_q)) begin
                        start_rej = 1'b1;
                    end else begin
                        state_d = bus.send_str ? SEND_STR : SEND_PAT;
                        idx_d   = '0;
                    end
                end
            end
            SEND_STR: begin
                if ((idx_q + SW'(1)) >= str_len_q) begin
                    state_d = SEND_PAT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + SW'(1);
                end
            end
            SEND_PAT: begin
                if ((idx_q + SW'(1)) >= SW'(pat_len_q)) begin
                    state_d = WAIT_RES;
                    idx_d   = '0;
                    tcnt_d  = '0;
                end else begin
                    idx_d = idx_q + SW'(1);
                end
            end
            WAIT_RES: begin
                if (bus.valid) begin
                    state_d   = IDLE;
                    fin_valid = 1'b1;
                end else if (tcnt_q == TW'(TIMEOUT)) begin
                    state_d     = IDLE;
                    fin_timeout = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Stream outputs are registered from the next state so they line up with it.
        if (state_d == SEND_STR) begin
            chardata_d = str_mem[idx_d[SAW-1:0]];
        end else if (state_d == SEND_PAT) begin
            chardata_d = pat_mem[idx_d[PAW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            if (bus.host_sel) begin
                pat_mem[pat_len_q[PAW-1:0]] <= bus.host_data;
            end else begin
                str_mem[str_len_q[SAW-1:0]] <= bus.host_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            str_len_q  <= '0;
            pat_len_q  <= '0;
            str_sent_q <= 1'b0;
        end else begin
            if (clr_acc) begin
                if (bus.host_sel) pat_len_q <= '0;
                else              str_len_q <= '0;
            end else if (wr_acc) begin
                if (bus.host_sel) pat_len_q <= pat_len_q + PW'(1);
                else              str_len_q <= str_len_q + SW'(1);
            end
            if (state_q == SEND_STR && state_d == SEND_PAT) begin
                str_sent_q <= 1'b1;
            end
            if (fin_valid || fin_timeout) begin
                pat_len_q <= '0;
            end
        end
    end

    // Engine side: each high cycle of isstring/ispattern carries one char on chardata;
    // the engine answers with a single valid cycle, which is only honoured in WAIT_RES.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q        <= 1'b0;
            host_err_q    <= 1'b0;
            isstring_q    <= 1'b0;
            ispattern_q   <= 1'b0;
            chardata_q    <= 8'h00;
            res_valid_q   <= 1'b0;
            res_match_q   <= 1'b0;
            res_index_q   <= 5'd0;
            res_timeout_q <= 1'b0;
        end else begin
            busy_q      <= (state_d != IDLE);
            host_err_q  <= wr_rej || start_rej;
            isstring_q  <= (state_d == SEND_STR);
            ispattern_q <= (state_d == SEND_PAT);
            chardata_q  <= chardata_d;
            res_valid_q <= fin_valid || fin_timeout;
            if (fin_valid) begin
                res_match_q   <= bus.match;
                res_index_q   <= bus.match_index;
                res_timeout_q <= 1'b0;
            end else if (fin_timeout) begin
                res_match_q   <= 1'b0;
                res_index_q   <= 5'd0;
                res_timeout_q <= 1'b1;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.host_err    = host_err_q;
    assign bus.isstring    = isstring_q;
    assign bus.ispattern   = ispattern_q;
    assign bus.chardata    = chardata_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_match   = res_match_q;
    assign bus.res_index   = res_index_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_sme_stim_driver.sv
// Bench for sme_stim_driver: plays host and engine, predicting every output from
// a queue-based model of the two buffers and the transaction rules.
module tb_sme_stim_driver;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int TIMEOUT = 1023;
    localparam int W       = 10;

    localparam int OP_WR    = 0;
    localparam int OP_CLR   = 1;
    localparam int OP_START = 2;
    localparam int OP_CLRWR = 3;

    typedef struct {
        int         op;
        logic       sel;
        logic [7:0] data;
        logic       s;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sme_stim_if bus();

    sme_stim_driver #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] str_m[$];
    logic [7:0] pat_m[$];
    bit         sent_m;
    logic [W-1:0] exp_q[$];
    vec_t       tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.host_wr_en = 0; bus.host_sel = 0; bus.host_clr = 0; bus.host_data = 0;
        bus.start = 0; bus.send_str = 0; bus.valid = 0; bus.match = 0; bus.match_index = 0;
    endtask

    task automatic model_reset();
        str_m.delete(); pat_m.delete(); sent_m = 0; exp_q.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {bus.busy, bus.host_err, bus.chardata, bus.isstring, bus.ispattern,
                   bus.res_valid, bus.res_match, bus.res_index, bus.res_timeout}, 0);
    endtask

    // All driver tasks are entered and left on a falling edge.
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
        chk_all_zero("reset_outputs");
    endtask

    task automatic host_op(input int op, input logic sel, input logic [7:0] data, input logic s,
                           output logic err, output logic bsy);
        bus.host_sel  = sel;
        bus.host_data = data;
        bus.send_str  = s;
        bus.host_wr_en = (op == OP_WR) || (op == OP_CLRWR);
        bus.host_clr   = (op == OP_CLR) || (op == OP_CLRWR);
        bus.start      = (op == OP_START);
        @(negedge clk);
        idle_inputs();
        err = bus.host_err;
        bsy = bus.busy;
        if (op == OP_WR) begin
            if (sel && pat_m.size() < PAT_MAX) pat_m.push_back(data);
            if (!sel && str_m.size() < STR_MAX) str_m.push_back(data);
        end else if (op == OP_CLR || op == OP_CLRWR) begin
            if (sel) pat_m.delete(); else str_m.delete();
        end
    endtask

    task automatic wr_char(input logic sel, input logic [7:0] data);
        logic exp_err, err, bsy;
        exp_err = sel ? (pat_m.size() == PAT_MAX) : (str_m.size() == STR_MAX);
        host_op(OP_WR, sel, data, 1'b0, err, bsy);
        chk("write_err", err, exp_err);
    endtask

    task automatic wr_str(input logic sel, input string txt);
        for (int i = 0; i < txt.len(); i++) wr_char(sel, txt[i]);
    endtask

    // vdelay < 0 means the engine never answers.
    task automatic run_txn(input logic s, input int vdelay, input logic m, input logic [4:0] mi,
                           input bit stray);
        bit rej;
        bit first;
        int cnt;
        logic [W-1:0] e;
        logic [6:0] held;
        rej = (pat_m.size() == 0) || (s && str_m.size() == 0) || (!s && !sent_m);
        exp_q.delete();
        if (s) foreach (str_m[i]) exp_q.push_back({2'b10, str_m[i]});
        foreach (pat_m[i]) exp_q.push_back({2'b01, pat_m[i]});
        bus.start = 1; bus.send_str = s;
        @(negedge clk);
        bus.start = 0;
        chk("start_err", bus.host_err, rej);
        if (rej) begin
            chk("busy_after_reject", bus.busy, 0);
            exp_q.delete();
            return;
        end
        first = 1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stream", {bus.isstring, bus.ispattern, bus.chardata}, e);
            chk("busy_send", bus.busy, 1);
            bus.valid = stray && first; bus.match = 1; bus.match_index = 5'd31;
            first = 0;
            @(negedge clk);
            bus.valid = 0; bus.match = 0; bus.match_index = 0;
        end
        chk("wait_bus_quiet", {bus.isstring, bus.ispattern, bus.chardata, bus.res_valid}, 0);
        if (vdelay >= 0) begin
            for (int k = 0; k < vdelay; k++) begin
                chk("no_early_result", bus.res_valid, 0);
                @(negedge clk);
            end
            bus.valid = 1; bus.match = m; bus.match_index = mi;
            @(negedge clk);
            idle_inputs();
            chk("res_valid", bus.res_valid, 1);
            chk("res_fields", {bus.res_match, bus.res_index, bus.res_timeout}, {m, mi, 1'b0});
            held = {m, mi, 1'b0};
        end else begin
            cnt = 0;
            while (!bus.res_valid && cnt < TIMEOUT + 10) begin
                cnt++;
                @(negedge clk);
            end
            chk("timeout_cycles", cnt, TIMEOUT + 1);
            chk("timeout_fields", {bus.res_match, bus.res_index, bus.res_timeout}, 7'b0000001);
            held = 7'b0000001;
        end
        chk("busy_at_result", bus.busy, 0);
        @(negedge clk);
        chk("res_valid_pulse", bus.res_valid, 0);
        chk("res_held", {bus.res_match, bus.res_index, bus.res_timeout}, held);
        pat_m.delete();
        if (s) sent_m = 1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic err, bsy;
        logic [7:0] c;
        tbl[0]  = '{OP_START, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[1]  = '{OP_START, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[2]  = '{OP_WR,    1'b1, "x",   1'b0, 1'b0};
        tbl[3]  = '{OP_START, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[4]  = '{OP_START, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5]  = '{OP_CLR,   1'b1, 8'h00, 1'b0, 1'b0};
        tbl[6]  = '{OP_START, 1'b0, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{OP_WR,    1'b0, "a",   1'b0, 1'b0};
        tbl[8]  = '{OP_START, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[9]  = '{OP_WR,    1'b1, "*",   1'b0, 1'b0};
        tbl[10] = '{OP_CLRWR, 1'b1, "?",   1'b0, 1'b0};
        tbl[11] = '{OP_START, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[12] = '{OP_WR,    1'b1, "$",   1'b0, 1'b0};

        idle_inputs();
        reset = 1;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            host_op(tbl[i].op, tbl[i].sel, tbl[i].data, tbl[i].s, err, bsy);
            chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
            chk($sformatf("tbl%0d_busy", i), bsy, 0);
        end
        run_txn(1'b1, 1, 1'b0, 5'd3, 0);

        do_reset();
        wr_str(1'b0, "abc d");
        wr_str(1'b1, "c d");
        run_txn(1'b1, 2, 1'b1, 5'd2, 0);
        wr_str(1'b1, "ab");
        run_txn(1'b0, 4, 1'b1, 5'd9, 0);

        do_reset();
        for (int i = 0; i < STR_MAX + 1; i++) wr_char(1'b0, 8'($urandom_range(0, 255)));
        wr_str(1'b1, "^.");
        run_txn(1'b1, 3, 1'b0, 5'd7, 0);

        wr_str(1'b1, "q");
        run_txn(1'b0, -1, 1'b1, 5'd1, 0);
        wr_str(1'b1, "zz");
        run_txn(1'b0, 0, 1'b1, 5'd5, 1);

        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                host_op(OP_CLR, 1'b0, 8'h00, 1'b0, err, bsy);
                chk("clr_err", err, 0);
            end
            repeat ($urandom_range(0, 6)) wr_char(1'b0, 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 9)) wr_char(1'b1, 8'($urandom_range(0, 255)));
            run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        do_reset();
        wr_str(1'b0, "hello");
        wr_str(1'b1, "lo");
        bus.start = 1; bus.send_str = 1;
        @(negedge clk);
        bus.start = 0;
        for (int k = 0; k < 3; k++) begin
            c = str_m[k];
            chk("abort_stream", {bus.isstring, bus.ispattern, bus.chardata}, {2'b10, c});
            @(negedge clk);
        end
        c = str_m[3];
        chk("abort_char3", {bus.isstring, bus.ispattern, bus.chardata}, {2'b10, c});
        reset = 1;
        bus.valid = 1; bus.match = 1; bus.match_index = 5'd4;
        @(negedge clk);
        reset = 0;
        chk("abort_strobes", {bus.isstring, bus.ispattern, bus.chardata, bus.busy}, 0);
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_result", bus.res_valid, 0);
            @(negedge clk);
        end
        idle_inputs();
        run_txn(1'b0, 0, 1'b0, 5'd0, 0);
        run_txn(1'b1, 0, 1'b0, 5'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
